// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// FSM encoding, register offsets, CTRL bit positions and mode codes.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } state_e;

  // Word offsets decoded from Addr[3:2]
  localparam logic [1:0] CTRL_OFS   = 2'd0;
  localparam logic [1:0] PRESET_OFS = 2'd1;
  localparam logic [1:0] COUNT_OFS  = 2'd2;

  // CTRL bit indices
  localparam int unsigned EN      = 0;
  localparam int unsigned MODE_LO = 1;
  localparam int unsigned MODE_HI = 2;
  localparam int unsigned IM      = 3;

  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] ONESHOT = 2'b00;
  localparam logic [1:0] RELOAD  = 2'b01;

  // Only the exact reload code reloads; 1x falls back to one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit memory-mapped down-counting timer with one-shot and auto-reload modes.
// Register file and control FSM share one clocked block since they update each other.
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Addr,
  input  logic             WE,
  input  logic [CNT_W-1:0] Din,
  output logic [CNT_W-1:0] Dout,
  output logic             IRQ
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  preset_q;
  logic [CNT_W-1:0]  count_q;
  logic              irq_flag_q;
  state_e            state_q;

  logic [1:0] reg_sel;
  logic [1:0] mode;
  logic       enable;

  assign reg_sel = Addr[3:2];
  assign mode    = ctrl_q[MODE_HI:MODE_LO];
  assign enable  = ctrl_q[EN];

  logic unused_addr;
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            irq_flag_q <= 1'b0;
            state_q    <= StLoad;
          end
        end
        StLoad: begin
          count_q <= preset_q;
          state_q <= StCnt;
        end
        StCnt: begin
          if (!enable) begin
            state_q <= StIdle;
          end else if (count_q > CNT_W'(1)) begin
            count_q <= count_q - CNT_W'(1);
          end else begin
            // Saturate at zero so a preset of 0 expires like a preset of 1
            count_q    <= '0;
            irq_flag_q <= 1'b1;
            state_q    <= StInt;
          end
        end
        StInt: begin
          if (is_reload(mode)) begin
            irq_flag_q <= 1'b0;
            state_q    <= enable ? StLoad : StIdle;
          end else begin
            ctrl_q[EN] <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Bus writes come last so a CPU write to CTRL overrides the FSM's Enable clear
      if (WE) begin
        case (reg_sel)
          CTRL_OFS:   ctrl_q   <= Din[CTRL_W-1:0];
          PRESET_OFS: preset_q <= Din;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    Dout = '0;
    case (reg_sel)
      CTRL_OFS:   Dout = CNT_W'(ctrl_q);
      PRESET_OFS: Dout = preset_q;
      COUNT_OFS:  Dout = count_q;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = ctrl_q[IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed timing scenarios with literal expectations,
// then randomized bus traffic compared every cycle against a behavioural model.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_vec;
  int n_err;

  timer_counter #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: register contents plus what the timer is currently doing
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;
  bit          m_loading;   // next edge copies PRESET into COUNT
  bit          m_counting;  // counting down
  bit          m_expired;   // count just reached its end

  task automatic model_clear();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
    m_loading = 1'b0; m_counting = 1'b0; m_expired = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
    bit en, periodic, drop_en;
    logic [1:0] sel;
    en       = m_ctrl[0];
    periodic = (m_ctrl[2:1] == 2'b01);
    drop_en  = 1'b0;
    sel      = a[3:2];
    if (m_loading) begin
      m_count    = m_preset;
      m_loading  = 1'b0;
      m_counting = 1'b1;
    end else if (m_counting) begin
      if (!en) m_counting = 1'b0;
      else if (m_count > 1) m_count = m_count - 1;
      else begin
        m_count = 0; m_flag = 1'b1; m_counting = 1'b0; m_expired = 1'b1;
      end
    end else if (m_expired) begin
      m_expired = 1'b0;
      if (periodic) begin
        m_flag    = 1'b0;
        m_loading = en;
      end else drop_en = 1'b1;
    end else if (en) begin
      m_flag    = 1'b0;
      m_loading = 1'b1;
    end
    if (drop_en) m_ctrl[0] = 1'b0;
    if (we && sel == 2'd0) m_ctrl = d[3:0];
    if (we && sel == 2'd1) m_preset = d;
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [1:0] sel;
    sel = a[3:2];
    case (sel)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One bus cycle: drive, compare against the model on the falling edge, advance the model
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    WE = we; Addr = a; Din = d;
    @(negedge clk);
    check("model_dout", Dout, exp_read(Addr));
    check("model_irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_flag});
    @(posedge clk);
    if (reset) model_clear();
    else model_edge(we, a, d);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h8, $urandom);
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp_d,
                      input logic exp_irq);
    WE = 1'b0; Addr = a;
    #1;
    check({name, "_dout"}, Dout, exp_d);
    check({name, "_irq"}, {31'd0, IRQ}, {31'd0, exp_irq});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    peek("rst_count", 32'h8, 32'd0, 1'b0);
    peek("rst_ctrl", 32'h0, 32'd0, 1'b0);
    step(1'b0, 32'h8, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sel;
    n_vec = 0; n_err = 0;
    reset = 1'b1; WE = 1'b0; Addr = 32'd0; Din = 32'd0;
    model_clear();
    @(posedge clk); #2;
    reset = 1'b0;

    // One-shot, PRESET=5, Enable written at edge 0
    do_reset();
    step(1'b1, 32'h4, 32'd5);
    step(1'b1, 32'h0, 32'h9);
    idle(2); peek("os_e2", 32'h8, 32'd5, 1'b0);
    idle(4); peek("os_e6", 32'h8, 32'd1, 1'b0);
    idle(1); peek("os_e7", 32'h8, 32'd0, 1'b1);
    idle(1); peek("os_e8", 32'h0, 32'h8, 1'b1);
    idle(3); peek("os_hold", 32'h0, 32'h8, 1'b1);
    step(1'b1, 32'h0, 32'h9);
    idle(1); peek("os_rearm", 32'h0, 32'h9, 1'b0);

    // Auto-reload, PRESET=3: one-cycle pulse every 5 cycles
    do_reset();
    step(1'b1, 32'h4, 32'd3);
    step(1'b1, 32'h0, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      idle(1);
      peek("ar_pulse", 32'h0, 32'hB, (k % 5) == 0);
      if (k == 7) peek("ar_reload", 32'h8, 32'd3, 1'b0);
    end

    // Disable mid-count freezes COUNT, re-enable reloads
    do_reset();
    step(1'b1, 32'h4, 32'd10);
    step(1'b1, 32'h0, 32'h9);
    idle(5);
    step(1'b1, 32'h0, 32'h8);
    idle(4); peek("dis_frozen", 32'h8, 32'd6, 1'b0);
    step(1'b1, 32'h0, 32'h9);
    idle(2); peek("dis_reload", 32'h8, 32'd10, 1'b0);

    // Masked expiry, then unmask; register access corners
    do_reset();
    step(1'b1, 32'h4, 32'd2);
    step(1'b1, 32'h0, 32'h1);
    idle(5); peek("mask_off", 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0, 32'h8); peek("mask_on", 32'h0, 32'h8, 1'b1);
    step(1'b1, 32'h8, 32'h1234); peek("wr_count", 32'h8, 32'd0, 1'b1);
    step(1'b1, 32'hC, 32'h55); peek("wr_unmap", 32'hC, 32'd0, 1'b1);
    step(1'b1, 32'h0, 32'hFFFF_FFFF); peek("ctrl_ff", 32'h0, 32'hF, 1'b1);
    peek("preset_keep", 32'h4, 32'd2, 1'b1);

    // PRESET=0 expires like PRESET=1
    do_reset();
    step(1'b1, 32'h4, 32'd0);
    step(1'b1, 32'h0, 32'h9);
    idle(2); peek("p0_e2", 32'h0, 32'h9, 1'b0);
    idle(1); peek("p0_e3", 32'h0, 32'h9, 1'b1);

    // PRESET rewritten while counting only applies at the next load
    do_reset();
    step(1'b1, 32'h4, 32'd8);
    step(1'b1, 32'h0, 32'h9);
    idle(3);
    step(1'b1, 32'h4, 32'd2);
    idle(5); peek("pw_e9", 32'h0, 32'h9, 1'b0);
    idle(1); peek("pw_e10", 32'h0, 32'h9, 1'b1);
    idle(1);
    step(1'b1, 32'h0, 32'h9);
    idle(2); peek("pw_next", 32'h8, 32'd2, 1'b0);

    // Asynchronous reset while counting
    do_reset();
    step(1'b1, 32'h4, 32'h20);
    step(1'b1, 32'h0, 32'h9);
    idle(18); peek("mid_cnt", 32'h8, 32'h10, 1'b0);
    do_reset();

    // Randomized bus traffic
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      a = $urandom;
      sel = a[3:2];
      if (r < 1) begin
        do_reset();
      end else if (r < 25) begin
        case (sel)
          2'd0:    d = $urandom_range(0, 15);
          2'd1:    d = $urandom_range(0, 9);
          default: d = $urandom;
        endcase
        step(1'b1, a, d);
      end else begin
        step(1'b0, a, $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
